// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states, master IDs
// and a grant decode helper.
package mem_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef logic mid_t;

  localparam mid_t MID_IM = 1'b0;
  localparam mid_t MID_DM = 1'b1;

  // Convert a one-hot grant vector into the granted master ID.
  function automatic mid_t onehot_to_mid(input logic [NUM_MASTERS-1:0] grant);
    return grant[MID_DM] ? MID_DM : MID_IM;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// master that was not granted last wins.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req_i,
  input  mid_t                   last_grant_i,
  output logic [NUM_MASTERS-1:0] grant_c_o
);

  always_comb begin
    grant_c_o = '0;
    if (req_i == 2'b11) begin
      if (last_grant_i == MID_IM) grant_c_o[MID_DM] = 1'b1;
      else                        grant_c_o[MID_IM] = 1'b1;
    end else begin
      grant_c_o = req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction and a data master onto one downstream memory port,
// one transaction outstanding at a time; all outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   im_req_addr,
  input  logic                im_req_valid,
  output logic [DATA_W-1:0]   im_resp_rdata,
  output logic                im_resp_valid,

  input  logic [ADDR_W-1:0]   dm_req_addr,
  input  logic [DATA_W-1:0]   dm_req_wdata,
  input  logic [DATA_W/8-1:0] dm_req_wmask,
  input  logic                dm_req_wen,
  input  logic                dm_req_valid,
  output logic [DATA_W-1:0]   dm_resp_rdata,
  output logic                dm_resp_valid,

  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  output logic                mem_req_wen,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,

  input  logic [DATA_W-1:0]   mem_resp_rdata,
  input  logic                mem_resp_valid
);

  localparam int unsigned MASK_W = DATA_W / 8;

  state_e              state_q, state_d;
  mid_t                last_grant_q, last_grant_d;
  mid_t                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                wen_q, wen_d;
  logic                req_valid_q, req_valid_d;
  logic [DATA_W-1:0]   im_rdata_q, im_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                im_valid_q, im_valid_d;
  logic                dm_valid_q, dm_valid_d;

  logic [NUM_MASTERS-1:0] req_c;
  logic [NUM_MASTERS-1:0] grant_c;

  assign req_c = {dm_req_valid, im_req_valid};

  rr_arbiter2 u_arb (
    .req_i        (req_c),
    .last_grant_i (last_grant_q),
    .grant_c_o    (grant_c)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    wen_d        = wen_q;
    req_valid_d  = 1'b0;
    im_rdata_d   = im_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    im_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_c) begin
          owner_d      = onehot_to_mid(grant_c);
          last_grant_d = onehot_to_mid(grant_c);
          req_valid_d  = 1'b1;
          state_d      = ST_ISSUE;
          if (onehot_to_mid(grant_c) == MID_DM) begin
            addr_d  = dm_req_addr;
            wdata_d = dm_req_wdata;
            wmask_d = dm_req_wmask;
            wen_d   = dm_req_wen;
          end else begin
            addr_d  = im_req_addr;
            wdata_d = '0;
            wmask_d = '0;
            wen_d   = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        req_valid_d = 1'b1;
        if (mem_req_ready) begin
          // Payload reads as zero whenever the request is not valid.
          req_valid_d = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          wmask_d     = '0;
          wen_d       = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ST_RESP;
          if (owner_q == MID_DM) begin
            dm_rdata_d = mem_resp_rdata;
            dm_valid_d = 1'b1;
          end else begin
            im_rdata_d = mem_resp_rdata;
            im_valid_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= MID_DM;
      owner_q      <= MID_IM;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wen_q        <= 1'b0;
      req_valid_q  <= 1'b0;
      im_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      im_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wen_q        <= wen_d;
      req_valid_q  <= req_valid_d;
      im_rdata_q   <= im_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      im_valid_q   <= im_valid_d;
      dm_valid_q   <= dm_valid_d;
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_valid = req_valid_q;
  assign im_resp_rdata = im_rdata_q;
  assign im_resp_valid = im_valid_q;
  assign dm_resp_rdata = dm_rdata_q;
  assign dm_resp_valid = dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: master and memory models driven just after
// the rising edge, DUT outputs sampled on the falling edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          wen;
  } req_t;

  typedef struct {
    mid_t          mid;
    logic [DW-1:0] rdata;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] im_req_addr;
  logic          im_req_valid;
  logic [DW-1:0] im_resp_rdata;
  logic          im_resp_valid;
  logic [AW-1:0] dm_req_addr;
  logic [DW-1:0] dm_req_wdata;
  logic [MW-1:0] dm_req_wmask;
  logic          dm_req_wen;
  logic          dm_req_valid;
  logic [DW-1:0] dm_resp_rdata;
  logic          dm_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [MW-1:0] mem_req_wmask;
  logic          mem_req_wen;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [DW-1:0] mem_resp_rdata;
  logic          mem_resp_valid;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .im_req_addr    (im_req_addr),
    .im_req_valid   (im_req_valid),
    .im_resp_rdata  (im_resp_rdata),
    .im_resp_valid  (im_resp_valid),
    .dm_req_addr    (dm_req_addr),
    .dm_req_wdata   (dm_req_wdata),
    .dm_req_wmask   (dm_req_wmask),
    .dm_req_wen     (dm_req_wen),
    .dm_req_valid   (dm_req_valid),
    .dm_resp_rdata  (dm_resp_rdata),
    .dm_resp_valid  (dm_resp_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_wen    (mem_req_wen),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_resp_valid (mem_resp_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  req_t          exp_req_q[$];
  resp_t         exp_resp_q[$];
  logic [AW-1:0] im_todo[$];
  req_t          dm_todo[$];

  bit            abort     = 1'b0;
  bit            hold_resp = 1'b0;
  bit            spur_en   = 1'b0;
  int            stall_cnt = 0;
  int            stall_seen = 0;
  int            im_start = 0, dm_start = 0;
  int            im_lat = 0, dm_lat = 0;
  int            im_pulses = 0, dm_pulses = 0;
  logic [DW-1:0] last_im_rd = '0, last_dm_rd = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream memory answers with a deterministic function of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return DW'(a) ^ 64'h0000_0000_8000_0013;
  endfunction

  // Master models: hold a request until its response pulse, then take the next.
  initial begin
    im_req_valid = 1'b0; im_req_addr = '0;
    dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_wmask = '0; dm_req_wen = 1'b0;
    forever begin
      req_t d;
      @(posedge clk); #1;
      if (abort) begin
        im_req_valid = 1'b0; im_req_addr = '0;
        dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_wmask = '0; dm_req_wen = 1'b0;
      end else begin
        if (im_req_valid && im_resp_valid) begin
          im_req_valid = 1'b0; im_req_addr = '0;
        end
        if (!im_req_valid && im_todo.size() > 0) begin
          im_req_addr = im_todo.pop_front(); im_req_valid = 1'b1; im_start = cyc;
        end
        if (dm_req_valid && dm_resp_valid) begin
          dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_wmask = '0; dm_req_wen = 1'b0;
        end
        if (!dm_req_valid && dm_todo.size() > 0) begin
          d = dm_todo.pop_front();
          dm_req_addr = d.addr; dm_req_wdata = d.wdata; dm_req_wmask = d.wmask; dm_req_wen = d.wen;
          dm_req_valid = 1'b1; dm_start = cyc;
        end
      end
    end
  end

  // Memory model: optional stall, one-cycle response, optional spurious responses.
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      bit            accepted;
      req_t          e;
      logic [AW-1:0] acc_addr;
      @(posedge clk); #1;
      accepted = mem_req_ready;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      if (accepted && !hold_resp) begin
        mem_resp_valid = 1'b1; mem_resp_rdata = mem_fn(acc_addr);
      end else if (spur_en) begin
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      if (mem_req_valid) begin
        if (exp_req_q.size() == 0) begin
          check_eq("req_unexpected", 64'(mem_req_valid), 64'd0);
        end else begin
          e = exp_req_q[0];
          if (stall_cnt > 0) begin
            check_eq("stall_addr",  mem_req_addr, e.addr);
            check_eq("stall_wdata", mem_req_wdata, e.wdata);
            check_eq("stall_wmask", 64'(mem_req_wmask), 64'(e.wmask));
            check_eq("stall_wen",   64'(mem_req_wen), 64'(e.wen));
            stall_cnt--; stall_seen++;
          end else begin
            check_eq("req_addr",  mem_req_addr, e.addr);
            check_eq("req_wdata", mem_req_wdata, e.wdata);
            check_eq("req_wmask", 64'(mem_req_wmask), 64'(e.wmask));
            check_eq("req_wen",   64'(mem_req_wen), 64'(e.wen));
            void'(exp_req_q.pop_front());
            acc_addr = mem_req_addr;
            mem_req_ready = 1'b1;
          end
        end
      end else begin
        check_eq("idle_payload_zero",
                 64'((|mem_req_addr) | (|mem_req_wdata) | (|mem_req_wmask) | mem_req_wen), 64'd0);
      end
    end
  end

  // Response monitor: pops the scoreboard on every response pulse.
  initial begin
    bit prev_im = 1'b0, prev_dm = 1'b0;
    resp_t r;
    forever begin
      @(negedge clk);
      if (im_resp_valid && dm_resp_valid) check_eq("both_resp", 64'd1, 64'd0);
      if (im_resp_valid && prev_im) check_eq("im_pulse_width", 64'd2, 64'd1);
      if (dm_resp_valid && prev_dm) check_eq("dm_pulse_width", 64'd2, 64'd1);
      if (im_resp_valid) begin
        im_pulses++; im_lat = cyc - im_start;
        if (exp_resp_q.size() == 0) check_eq("im_resp_unexpected", 64'd1, 64'd0);
        else begin
          r = exp_resp_q.pop_front();
          check_eq("resp_mid_im", 64'(MID_IM), 64'(r.mid));
          check_eq("im_rdata", im_resp_rdata, r.rdata);
          last_im_rd = r.rdata;
        end
      end
      if (dm_resp_valid) begin
        dm_pulses++; dm_lat = cyc - dm_start;
        if (exp_resp_q.size() == 0) check_eq("dm_resp_unexpected", 64'd1, 64'd0);
        else begin
          r = exp_resp_q.pop_front();
          check_eq("resp_mid_dm", 64'(MID_DM), 64'(r.mid));
          check_eq("dm_rdata", dm_resp_rdata, r.rdata);
          last_dm_rd = r.rdata;
        end
      end
      prev_im = im_resp_valid;
      prev_dm = dm_resp_valid;
    end
  end

  task automatic push_im(input logic [AW-1:0] a);
    req_t q;
    resp_t r;
    q.addr = a; q.wdata = '0; q.wmask = '0; q.wen = 1'b0;
    r.mid = MID_IM; r.rdata = mem_fn(a);
    exp_req_q.push_back(q); exp_resp_q.push_back(r); im_todo.push_back(a);
  endtask

  task automatic push_dm(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [MW-1:0] wm, input logic we);
    req_t q;
    resp_t r;
    q.addr = a; q.wdata = wd; q.wmask = wm; q.wen = we;
    r.mid = MID_DM; r.rdata = mem_fn(a);
    exp_req_q.push_back(q); exp_resp_q.push_back(r); dm_todo.push_back(q);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_resp_q.size() > 0 || im_todo.size() > 0 || dm_todo.size() > 0 ||
            im_req_valid || dm_req_valid) && n < budget) begin
      @(negedge clk); n++;
    end
    check_eq(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    check_eq({tag, "_req_addr"},  mem_req_addr, 64'd0);
    check_eq({tag, "_im_valid"},  64'(im_resp_valid), 64'd0);
    check_eq({tag, "_dm_valid"},  64'(dm_resp_valid), 64'd0);
    check_eq({tag, "_im_rdata"},  im_resp_rdata, 64'd0);
    check_eq({tag, "_dm_rdata"},  dm_resp_rdata, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int p_im, p_dm, n;
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    // Lone instruction fetch with minimum latency.
    push_im(64'h0000_0000_8000_0000);
    wait_done("t025_done", 40);
    check_eq("t025_latency", 64'(im_lat), 64'd3);
    check_eq("t025_rdata_hold", im_resp_rdata, 64'h13);

    // Simultaneous requests after reset: im first, then the dm write.
    do_reset();
    p_im = im_pulses; p_dm = dm_pulses;
    push_im(64'h2000);
    push_dm(64'h1000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1);
    wait_done("t026_done", 60);
    check_eq("t026_im_pulses", 64'(im_pulses - p_im), 64'd1);
    check_eq("t026_dm_pulses", 64'(dm_pulses - p_dm), 64'd1);

    // Downstream not ready for 5 cycles.
    stall_seen = 0; stall_cnt = 5;
    push_dm(64'h3000, 64'h0123_4567_89AB_CDEF, 8'hF0, 1'b1);
    wait_done("t027_done", 60);
    check_eq("t027_stall_cycles", 64'(stall_seen), 64'd5);

    // Spurious responses in IDLE, then during a stalled ISSUE.
    p_im = im_pulses; p_dm = dm_pulses;
    spur_en = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t028_idle_im_rdata", im_resp_rdata, last_im_rd);
    check_eq("t028_idle_dm_rdata", dm_resp_rdata, last_dm_rd);
    check_eq("t028_idle_no_pulse", 64'((im_pulses - p_im) + (dm_pulses - p_dm)), 64'd0);
    stall_cnt = 3;
    push_im(64'h4000);
    wait_done("t028_done", 60);
    spur_en = 1'b0;
    check_eq("t028_one_pulse", 64'(im_pulses - p_im), 64'd1);
    check_eq("t028_rdata", im_resp_rdata, mem_fn(64'h4000));

    // Reset while waiting for the downstream response; the late response is ignored.
    p_im = im_pulses; p_dm = dm_pulses;
    hold_resp = 1'b1;
    im_todo.push_back(64'h5000);
    begin
      req_t q;
      q.addr = 64'h5000; q.wdata = '0; q.wmask = '0; q.wen = 1'b0;
      exp_req_q.push_back(q);
    end
    n = 0;
    while (exp_req_q.size() > 0 && n < 40) begin @(negedge clk); n++; end
    check_eq("t029_accepted", 64'(n < 40), 64'd1);
    @(negedge clk);
    check_eq("t029_in_wait", 64'(mem_req_valid), 64'd0);
    rst = 1'b0; abort = 1'b1;
    @(negedge clk);
    check_all_zero("t029_rst");
    rst = 1'b1; hold_resp = 1'b0; spur_en = 1'b1;
    repeat (3) @(negedge clk);
    spur_en = 1'b0;
    check_all_zero("t029_after");
    check_eq("t029_no_pulse", 64'((im_pulses - p_im) + (dm_pulses - p_dm)), 64'd0);
    abort = 1'b0;
    @(negedge clk);

    // Both masters streaming: grants must alternate im, dm, im, dm ...
    for (int i = 0; i < 4; i++) begin
      push_im(64'h6000 + 64'(i * 8));
      push_dm(64'h7000 + 64'(i * 8), {$urandom, $urandom}, MW'($urandom), 1'b0);
    end
    p_im = im_pulses; p_dm = dm_pulses;
    wait_done("t030_done", 200);
    check_eq("t030_im_pulses", 64'(im_pulses - p_im), 64'd4);
    check_eq("t030_dm_pulses", 64'(dm_pulses - p_dm), 64'd4);
    check_eq("t030_req_q_empty", 64'(exp_req_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width; mask width is DATA_W/8.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports im_req_addr in ADDR_W, im_req_valid in 1, im_resp_rdata out DATA_W, im_resp_valid out 1: instruction master.
REQ-006 SHALL have ports dm_req_addr in ADDR_W, dm_req_wdata in DATA_W, dm_req_wmask in DATA_W/8, dm_req_wen in 1, dm_req_valid in 1, dm_resp_rdata out DATA_W, dm_resp_valid out 1: data master.
REQ-007 SHALL have ports mem_req_addr out ADDR_W, mem_req_wdata out DATA_W, mem_req_wmask out DATA_W/8, mem_req_wen out 1, mem_req_valid out 1, mem_req_ready in 1: shared downstream request.
REQ-008 SHALL have ports mem_resp_rdata in DATA_W, mem_resp_valid in 1: shared downstream response.

Function
REQ-009 Upstream protocol: master holds req_valid and payload stable until its resp_valid pulse; resp_valid SHALL be a one-cycle pulse.
REQ-010 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-011 IDLE: if any req_valid, SHALL grant one master, latch its addr/wdata/wmask/wen (im: wdata=0, wmask=0, wen=0), go ISSUE; else stay.
REQ-012 Arbitration: single requester always granted; both requesting SHALL grant the master not granted last (round-robin, last_grant register).
REQ-013 ISSUE: mem_req_valid=1 with latched payload stable; on mem_req_ready=1 go WAIT; else stay.
REQ-014 mem_resp_valid SHALL be ignored in every state except WAIT (downstream responds no earlier than cycle after acceptance).
REQ-015 WAIT: on mem_resp_valid=1 latch mem_resp_rdata, go RESP.
REQ-016 RESP: granted master's resp_valid=1 with latched rdata, other master's resp_valid=0; go IDLE unconditionally; req_valid not sampled in RESP.
REQ-017 dm write: dm_resp_valid SHALL still pulse (rdata = whatever downstream returned) to complete the transaction.
REQ-018 Minimum latency: req seen in IDLE cycle N -> mem_req_valid N+1 -> (ready N+1, resp N+2) -> resp_valid N+3.
REQ-019 Outputs SHALL be registered; mem_req_* payload SHALL be 0 when mem_req_valid=0.
REQ-020 resp_rdata outputs SHALL hold last latched value between pulses.

Reset
REQ-021 rst=0 at a clock edge SHALL force IDLE, mem_req_valid=0, im/dm_resp_valid=0, latched payload/rdata=0, last_grant=DM (so im wins first tie).
REQ-022 Reset mid-transaction SHALL abandon it; no resp pulse issued; late mem_resp_valid after reset ignored per REQ-014.

Structure
REQ-023 State encodings and master IDs (MID_IM=0, MID_DM=1) SHALL live in the shared definitions header.
REQ-024 Grant logic SHALL be sub-module rr_arbiter2 (2 requests, last_grant in, grant one-hot out); rest in mem_arbiter.

Verification
REQ-025 im only, addr 0x8000_0000, ready=1, resp next cycle rdata 0x0000_0013 -> mem_req_addr 0x8000_0000 wen=0, im_resp_valid pulse 3 cycles after request, rdata 0x13.
REQ-026 im and dm valid same cycle after reset -> im granted first, then dm; dm addr 0x1000, wdata 0xDEADBEEF, wmask 0x0F, wen=1 appears on mem_req_*; each resp_valid pulses exactly once.
REQ-027 mem_req_ready held 0 for 5 cycles -> mem_req_valid and payload stable all 5 cycles, no state advance.
REQ-028 Spurious mem_resp_valid in IDLE and ISSUE -> no resp_valid pulse, rdata unchanged.
REQ-029 rst=0 while in WAIT, then mem_resp_valid=1 -> IDLE, no resp pulse, all outputs 0.
REQ-030 Both masters continuously requesting for 8 transactions -> grants alternate im,dm,im,dm...
